// File: rtl/sequenciador_servo.sv
// Position sequencer for the servo PWM block: a 0->7->0 sweep with a programmable
// dwell per step, or a manual position pass-through. It also exports its state code for the debug displays.
module sequenciador_servo #(
    parameter int TEMPO_PASSO = 50000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ligar,
    input  logic       modo,
    input  logic       pausar,
    input  logic [2:0] posicao_manual,
    output logic [2:0] posicao,
    output logic       fim_ciclo,
    output logic [1:0] db_estado
);

    localparam int TW = $clog2(TEMPO_PASSO);
    localparam logic [TW-1:0] ULTIMO = TW'(TEMPO_PASSO - 1);

    // Encodings double as the debug display codes.
    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        SUBINDO  = 2'd1,
        DESCENDO = 2'd2,
        MANUAL   = 2'd3
    } estado_t;

    estado_t         estado, estado_n;
    logic [TW-1:0]   timer, timer_n;
    logic [2:0]      posicao_n;
    logic            fim_n;
    logic            tick;
    estado_t         entrada_varredura;

    assign tick = (timer == ULTIMO);

    // Sweep entry direction depends on where the servo currently is.
    assign entrada_varredura = (posicao != 3'd7) ? SUBINDO : DESCENDO;

    // NOTE: every state element is cleared by the async reset; there is no
    // memory array here, so nothing is left uninitialised out of reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado    <= OCIOSO;
            timer     <= '0;
            posicao   <= 3'd0;
            fim_ciclo <= 1'b0;
        end else begin
            // NOTE: non-blocking here so all registers update from the same
            // pre-edge values; blocking would create order-dependent state.
            estado    <= estado_n;
            timer     <= timer_n;
            posicao   <= posicao_n;
            fim_ciclo <= fim_n;
        end
    end

    always_comb begin
        // NOTE: defaults first so every path assigns every output; a missing
        // branch would otherwise infer a latch.
        estado_n  = estado;
        timer_n   = timer;
        posicao_n = posicao;
        fim_n     = 1'b0;

        if (!ligar) begin
            estado_n = OCIOSO;
            timer_n  = '0;
        end else begin
            unique case (estado)
                OCIOSO: begin
                    timer_n  = '0;
                    estado_n = modo ? MANUAL : entrada_varredura;
                end

                MANUAL: begin
                    timer_n = '0;
                    if (modo) begin
                        posicao_n = posicao_manual;
                    end else begin
                        estado_n = entrada_varredura;
                    end
                end

                SUBINDO, DESCENDO: begin
                    if (modo) begin
                        estado_n = MANUAL;
                        timer_n  = '0;
                    end else if (!pausar) begin
                        if (!tick) begin
                            timer_n = timer + 1'b1;
                        end else begin
                            timer_n = '0;
                            if (estado == SUBINDO) begin
                                posicao_n = posicao + 3'd1;
                                if (posicao == 3'd6) begin
                                    estado_n = DESCENDO;
                                end
                            end else begin
                                posicao_n = posicao - 3'd1;
                                // Landing on 0 closes one full 0->7->0 sweep.
                                if (posicao == 3'd1) begin
                                    estado_n = SUBINDO;
                                    fim_n    = 1'b1;
                                end
                            end
                        end
                    end
                end

                default: begin
                    estado_n = OCIOSO;
                    timer_n  = '0;
                end
            endcase
        end
    end

    assign db_estado = estado;

endmodule

// File: doc/sequenciador_servo.md
Name: sequenciador_servo

Overview:
- Position sequencer that drives the 3-bit `posicao` input of the servo PWM controller.
- Sweep mode: steps the servo 0→7→0 continuously, with a programmable dwell per step.
- Manual mode: forwards a user-selected position.
- Sits between the board switches/buttons and the servo control block. Also exports state for the debug displays.

Parameters:
- TEMPO_PASSO, 50000000: clock cycles per sweep step (1 s at 50 MHz). Legal range ≥ 2. Timer width is clog2(TEMPO_PASSO).

Ports:
- clock  input  1  system clock, all state rising-edge.
- reset  input  1  asynchronous, active-low reset.
- ligar  input  1  enable; 0 forces OCIOSO.
- modo  input  1  0 = automatic sweep, 1 = manual.
- pausar  input  1  in sweep states, freezes timer and position.
- posicao_manual  input  3  target position used in MANUAL.
- posicao  output  3  registered position to the servo PWM block.
- fim_ciclo  output  1  one-cycle pulse when a full 0→7→0 sweep completes.
- db_estado  output  2  state code: OCIOSO=0, SUBINDO=1, DESCENDO=2, MANUAL=3.

Behaviour:
- Reset (reset=0, asynchronous): posicao=0, state=OCIOSO, timer=0, fim_ciclo=0, db_estado=0. All outputs are registered.
- Priority each cycle: ligar=0 > modo > pausar > timer tick.
- Tick: timer==TEMPO_PASSO-1. On a tick, timer returns to 0; otherwise timer increments. Timer runs only in SUBINDO/DESCENDO with pausar=0.
- Consequence: a step occurs every TEMPO_PASSO cycles. The first step occurs TEMPO_PASSO cycles after entering a sweep state.
- OCIOSO:
  - posicao holds its value; timer=0.
  - If ligar=1 and modo=1: go to MANUAL.
  - If ligar=1 and modo=0: go to SUBINDO if posicao<7, else DESCENDO.
- SUBINDO:
  - On tick: posicao←posicao+1.
  - If the new value is 7, go to DESCENDO.
- DESCENDO:
  - On tick: posicao←posicao-1.
  - If the new value is 0, go to SUBINDO and assert fim_ciclo for exactly the cycle after that edge.
  - A full sweep from 0 is 14 ticks.
- pausar=1 in SUBINDO/DESCENDO: timer and posicao hold; state unchanged. Resuming continues from the held timer value.
- MANUAL:
  - posicao←posicao_manual every cycle (1-cycle latency); timer held at 0.
  - modo→0 while ligar=1: go to SUBINDO if posicao<7, else DESCENDO. Timer starts from 0.
- Sweep state with modo=1 (ligar=1): go to MANUAL next cycle; timer cleared.
- ligar=0 in any state: go to OCIOSO next cycle. posicao holds its last value; timer cleared; no fim_ciclo.
- fim_ciclo is never asserted outside the DESCENDO→SUBINDO transition.
- Wrap-around: posicao never increments past 7 or decrements below 0. The direction change at the endpoints guarantees this.
- Reset asserted mid-sweep or mid-pulse: immediate return to the reset values, regardless of clock.
- db_estado is combinationally derived from the state register, so it has no extra latency.

Test Plan (TEMPO_PASSO=4):
- Reset with ligar=1, modo=0, then release: posicao=0 and db_estado=1. posicao=1 four cycles after release, and increments every 4 cycles up to 7. At 7, db_estado=2.
- Full sweep: after 56 cycles in sweep from posicao=0, posicao returns to 0. fim_ciclo is high for exactly one cycle, then db_estado=1; fim_ciclo pulses once per 56 cycles thereafter.
- pausar=1 for 10 cycles at posicao=3 mid-dwell: posicao stays 3. After release, the remaining dwell completes and posicao=4 with no skipped step.
- modo=1, posicao_manual=5 during SUBINDO: db_estado=3, posicao=5 within 2 cycles.
  - Then modo=0: SUBINDO resumes from 5, and posicao=6 after 4 cycles.
  - With posicao_manual=7, modo=0 instead enters DESCENDO.
- ligar=0 at posicao=6: db_estado=0 next cycle and posicao holds 6. With ligar=1 again, modo=0: SUBINDO, posicao=7 after 4 cycles, then DESCENDO.
- reset pulsed low between clock edges mid-sweep: posicao=0, db_estado=0 and fim_ciclo=0 asynchronously, before the next rising edge.
